// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the multi-cycle PC / memory-handshake control FSM.
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] PC_SRC_PC4    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_MEM  = 2'b01;
    localparam logic [1:0] WB_SEL_LINK = 2'b10;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes; expired flags TIMEOUT cycles of waiting.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);
    localparam int W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    // Holds at TIMEOUT; with TIMEOUT=0 it never leaves zero and never expires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (count && cnt != W'(TIMEOUT))
            cnt <= cnt + 1'b1;
    end

    assign expired = (TIMEOUT != 0) && (cnt == W'(TIMEOUT));

endmodule

// File: rtl/pc_control_fsm.sv
// Multi-cycle control FSM sequencing PC updates and imem/dmem handshakes for an RV32I subset.
module pc_control_fsm
    import pc_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             trap
);
    state_t state_q, state_d;
    logic   wait_ready, wait_count, wait_clear, wait_expired;

    assign wait_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;
    assign wait_count = ((state_q == S_FETCH) || (state_q == S_MEM)) && !wait_ready;
    // Any state change restarts the count, so entry to FETCH/MEM always starts at zero.
    assign wait_clear = (state_d != state_q);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .count   (wait_count),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_PC4;
        reg_write = 1'b0;
        wb_sel    = WB_SEL_ALU;
        retire    = 1'b0;
        trap      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: state_d = is_legal(opcode) ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (opcode)
                    OP_R, OP_I:   state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ: begin
                        pc_write = branch_taken;
                        pc_src   = PC_SRC_BRANCH;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = PC_SRC_JUMP;
                        reg_write = 1'b1;
                        wb_sel    = WB_SEL_LINK;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                mem_write = (opcode == OP_SW);
                if (dmem_ready) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OP_LW) ? WB_SEL_MEM : WB_SEL_ALU;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: trap = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instr_count <= '0;
        else if (retire)
            instr_count <= instr_count + 1'b1;
    end

endmodule
